// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the parametrised serial pattern detector.
package seq_det_pkg;

    localparam int PAT_W     = 32;
    localparam int CFG_LEN_W = 6;

    localparam logic [7:0] DEF_PATTERN_C = 8'b0000_1010;
    localparam int         DEF_LEN_C     = 4;
    localparam bit         DEF_OVERLAP_C = 1'b1;

    typedef struct packed {
        logic [PAT_W-1:0]     pattern;
        logic [CFG_LEN_W-1:0] len;
        logic                 overlap;
    } cfg_t;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating event counter with synchronous clear.
module seq_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && count != '1) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with match pulse and counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               MAX_LEN     = 8,
    parameter int               CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = DEF_PATTERN_C,
    parameter int               DEF_LEN     = DEF_LEN_C,
    parameter bit               DEF_OVERLAP = DEF_OVERLAP_C,
    localparam int              LEN_W       = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               cfg_err,
    input  logic               din_valid,
    input  logic               din,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    input  logic               cnt_clr
);

    localparam cfg_t DEF_CFG = '{
        pattern: PAT_W'(DEF_PATTERN),
        len:     CFG_LEN_W'(DEF_LEN),
        overlap: DEF_OVERLAP
    };

    cfg_t               cfg_q;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;

    logic [MAX_LEN-1:0] cur_pat;
    logic [LEN_W-1:0]   cur_len;
    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   fill_next;
    logic [MAX_LEN-1:0] mask;
    logic               accept;
    logic               cfg_ok;
    logic               hit;
    logic               unused_cfg;

    assign cur_pat    = cfg_q.pattern[MAX_LEN-1:0];
    assign cur_len    = cfg_q.len[LEN_W-1:0];
    assign unused_cfg = ^cfg_q;
    assign accept     = din_valid && !cfg_we && !reset;
    assign cfg_ok     = (cfg_len != '0) && (int'(cfg_len) <= MAX_LEN);

    // Only the low len bits of the window take part in the compare.
    always_comb begin
        hist_next = {hist[MAX_LEN-2:0], din};
        fill_next = fill;
        if (int'(fill) < MAX_LEN) begin
            fill_next = fill + LEN_W'(1);
        end
        mask = {MAX_LEN{1'b1}} >> (MAX_LEN - int'(cur_len));
        hit  = accept
            && (fill_next >= cur_len)
            && (((hist_next ^ cur_pat) & mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q   <= DEF_CFG;
            hist    <= '0;
            fill    <= '0;
            match   <= 1'b0;
            cfg_err <= 1'b0;
        end else if (cfg_we) begin
            hist    <= '0;
            fill    <= '0;
            match   <= 1'b0;
            cfg_err <= !cfg_ok;
            if (cfg_ok) begin
                cfg_q <= '{
                    pattern: PAT_W'(cfg_pattern),
                    len:     CFG_LEN_W'(cfg_len),
                    overlap: cfg_overlap
                };
            end
        end else begin
            cfg_err <= 1'b0;
            match   <= hit;
            if (din_valid) begin
                hist <= hist_next;
                fill <= (hit && !cfg_q.overlap) ? '0 : fill_next;
            end
        end
    end

    seq_sat_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (hit),
        .clr  (cnt_clr),
        .count(match_count)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param (16-bit and 2-bit counter builds).
module tb_seq_detector_param;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_we = 1'b0;
    logic [7:0]  cfg_pattern = '0;
    logic [3:0]  cfg_len = '0;
    logic        cfg_overlap = 1'b0;
    logic        din_valid = 1'b0;
    logic        din = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        cfg_err, cfg_err2;
    logic        match, match2;
    logic [15:0] match_count;
    logic [1:0]  match_count2;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] m_hist, m_pat;
    int          m_fill, m_len, m_cnt, m_cnt2;
    logic        m_ov;

    logic exp_m[$];
    int   exp_c[$];
    int   exp_c2[$];
    logic exp_e[$];

    logic em, ee;
    int   ec, ec2;

    always #5 clk = ~clk;

    seq_detector_param dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_err(cfg_err),
        .din_valid(din_valid), .din(din), .match(match),
        .match_count(match_count), .cnt_clr(cnt_clr)
    );

    seq_detector_param #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_err(cfg_err2),
        .din_valid(din_valid), .din(din), .match(match2),
        .match_count(match_count2), .cnt_clr(cnt_clr)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        m_hist = '0; m_fill = 0; m_pat = 32'h0A; m_len = 4; m_ov = 1'b1;
        m_cnt = 0; m_cnt2 = 0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic drive_bit(input logic v, input logic b, input logic clr);
        logic hit;
        @(negedge clk);
        din_valid = v; din = b; cnt_clr = clr;
        hit = 1'b0;
        if (v) begin
            m_hist = {m_hist[30:0], b};
            if (m_fill < 8) m_fill++;
            hit = (m_fill >= m_len);
            for (int i = 0; i < m_len; i++)
                if (m_hist[i] != m_pat[i]) hit = 1'b0;
            if (hit && !m_ov) m_fill = 0;
        end
        if (clr) begin
            m_cnt = 0; m_cnt2 = 0;
        end else if (hit) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        exp_m.push_back(hit); exp_c.push_back(m_cnt); exp_c2.push_back(m_cnt2);
        @(posedge clk); #1;
        din_valid = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic drive_cfg(input logic [7:0] p, input int l, input logic ov, input logic v);
        logic bad;
        @(negedge clk);
        cfg_we = 1'b1; cfg_pattern = p; cfg_len = 4'(l); cfg_overlap = ov;
        din_valid = v; din = 1'b0;
        bad = !(l >= 1 && l <= 8);
        if (!bad) begin
            m_pat = 32'(p); m_len = l; m_ov = ov;
        end
        m_hist = '0; m_fill = 0;
        exp_e.push_back(bad);
        @(posedge clk); #1;
        cfg_we = 1'b0; din_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (match !== 1'b0 || match_count !== 16'd0 || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: match=%b cnt=%0d err=%b want 0/0/0", match, match_count, cfg_err);
        end
        n_chk++;
        if (match2 !== 1'b0 || match_count2 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset2: match=%b cnt=%0d want 0/0", match2, match_count2);
        end
    endtask

    task automatic run_stream(input string tag, input logic [15:0] s, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            drive_bit(1'b1, s[i], 1'b0);
            em = exp_m.pop_front(); ec = exp_c.pop_front(); ec2 = exp_c2.pop_front();
            n_chk++;
            if (match !== em || match_count !== 16'(ec)) begin
                n_fail++;
                $display("FAIL %s bit%0d: match=%b cnt=%0d want %b/%0d", tag, n - 1 - i, match, match_count, em, ec);
            end
        end
    endtask

    task automatic test_overlap();
        do_reset();
        run_stream("overlap", 16'b1010100, 7);
        n_chk++;
        if (match_count !== 16'd2) begin
            n_fail++;
            $display("FAIL overlap_total: cnt=%0d want 2", match_count);
        end
    endtask

    task automatic test_no_overlap();
        do_reset();
        drive_cfg(8'b1010, 4, 1'b0, 1'b1);
        ee = exp_e.pop_front();
        n_chk++;
        if (cfg_err !== ee || match !== 1'b0) begin
            n_fail++;
            $display("FAIL noovl_cfg: err=%b match=%b want %b/0", cfg_err, match, ee);
        end
        run_stream("noovl", 16'b1010100, 7);
        n_chk++;
        if (match_count !== 16'd1) begin
            n_fail++;
            $display("FAIL noovl_total: cnt=%0d want 1", match_count);
        end
    endtask

    task automatic test_idle();
        logic [6:0] v = 7'b1100011;
        logic [6:0] b = 7'b1000010;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            drive_bit(v[i], b[i], 1'b0);
            em = exp_m.pop_front(); ec = exp_c.pop_front(); ec2 = exp_c2.pop_front();
            n_chk++;
            if (match !== em || match_count !== 16'(ec)) begin
                n_fail++;
                $display("FAIL idle step%0d: match=%b cnt=%0d want %b/%0d", 6 - i, match, match_count, em, ec);
            end
        end
        n_chk++;
        if (match_count !== 16'd1) begin
            n_fail++;
            $display("FAIL idle_total: cnt=%0d want 1", match_count);
        end
    endtask

    task automatic test_bad_cfg();
        int lens[2] = '{0, 9};
        do_reset();
        foreach (lens[k]) begin
            drive_cfg(8'b0110, lens[k], 1'b0, 1'b0);
            ee = exp_e.pop_front();
            n_chk++;
            if (cfg_err !== ee || cfg_err2 !== ee) begin
                n_fail++;
                $display("FAIL badcfg_err len%0d: err=%b want %b", lens[k], cfg_err, ee);
            end
            run_stream("badcfg", 16'b1010, 4);
            n_chk++;
            if (cfg_err !== 1'b0 || match_count !== 16'(k + 1)) begin
                n_fail++;
                $display("FAIL badcfg_after len%0d: err=%b cnt=%0d want 0/%0d", lens[k], cfg_err, match_count, k + 1);
            end
        end
    endtask

    task automatic test_saturate();
        int want[5] = '{1, 2, 3, 3, 3};
        do_reset();
        drive_cfg(8'b1, 1, 1'b1, 1'b0);
        ee = exp_e.pop_front();
        for (int i = 0; i < 6; i++) begin
            drive_bit(1'b1, 1'b1, i == 5);
            em = exp_m.pop_front(); ec = exp_c.pop_front(); ec2 = exp_c2.pop_front();
            n_chk++;
            if (match2 !== em || match_count2 !== 2'(ec2)
                || (i < 5 && match_count2 !== 2'(want[i]))) begin
                n_fail++;
                $display("FAIL sat step%0d: match=%b cnt=%0d want %b/%0d", i, match2, match_count2, em, ec2);
            end
        end
        n_chk++;
        if (match !== 1'b1 || match_count !== 16'd0) begin
            n_fail++;
            $display("FAIL clr_prio: match=%b cnt=%0d want 1/0", match, match_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_stream("mid_pre", 16'b101, 3);
        do_reset();
        n_chk++;
        if (match !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: match=%b want 0", match);
        end
        run_stream("mid_post", 16'b0, 1);
        run_stream("mid_full", 16'b1010, 4);
        n_chk++;
        if (match !== 1'b1 || match_count !== 16'd1) begin
            n_fail++;
            $display("FAIL mid_final: match=%b cnt=%0d want 1/1", match, match_count);
        end
    endtask

    initial begin
        m_hist = '0; m_pat = 32'h0A; m_fill = 0; m_len = 4; m_ov = 1'b1;
        m_cnt = 0; m_cnt2 = 0;
        test_reset();
        test_overlap();
        test_no_overlap();
        test_idle();
        test_bad_cfg();
        test_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
